// File: rtl/trace_checker_pkg.sv
// Shared types for the write-back trace checker: FSM states, the captured
// entry layout and the write-enable to byte-mask expansion.
package trace_checker_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ERROR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // pc + wnum + masked wdata + 4-bit byte mask
    localparam int ENTRY_W = 32 + 5 + 32 + 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } entry_t;

    // Expand per-byte write enables into a 32-bit data mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        byte_mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/trace_checker_if.sv
// Trace bus between the test environment and the checker: the core's
// write-back trace plus the golden-trace valid/ready stream.
interface trace_checker_if;

    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;

    modport master (
        output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        output ref_valid, ref_pc, ref_wnum, ref_wdata,
        input  ref_ready
    );

    modport slave (
        input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata,
        input  ref_valid, ref_pc, ref_wnum, ref_wdata,
        output ref_ready
    );

endinterface

// File: rtl/trace_checker_fifo.sv
// Synchronous FIFO holding captured write-back entries. Pointers carry one
// extra wrap bit so full and empty are distinguished by the MSB.
module trace_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/trace_checker.sv
// Write-back trace checker: captures register writes from the core's trace
// port, compares them in order with a golden stream, latches the first
// failure and flags completion once the end PC has retired and drained.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] END_PC     = 32'h1c000100
) (
    input  logic                  clk,
    input  logic                  reset,
    trace_checker_if.slave        bus,
    output logic                  mismatch,
    output logic                  overflow,
    output logic                  done,
    output logic [31:0]           err_pc,
    output logic [4:0]            err_wnum,
    output logic [31:0]           err_wdata,
    output logic [31:0]           retire_cnt
);

    state_t             state;
    entry_t             cap_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] head_bits;
    logic               full;
    logic               empty;
    logic               capture;
    logic               fire;
    logic               hit;
    logic               push;
    logic               over;
    logic               end_now;
    logic               end_seen;
    logic [31:0]        prev_pc;

    // A register write is architecturally visible only with some byte
    // enabled and a non-zero destination; ERROR ignores the trace entirely.
    assign capture = (bus.debug_wb_rf_we != 4'd0) && (bus.debug_wb_rf_wnum != 5'd0)
                     && (state != ST_ERROR);

    assign cap_entry = '{pc:    bus.debug_wb_pc,
                         wnum:  bus.debug_wb_rf_wnum,
                         wdata: bus.debug_wb_rf_wdata & byte_mask(bus.debug_wb_rf_we),
                         mask:  bus.debug_wb_rf_we};

    assign head          = head_bits;
    assign bus.ref_ready = (state == ST_RUN) && !empty;
    assign fire          = bus.ref_valid && bus.ref_ready;

    // Golden data is masked with the byte enables stored alongside the entry.
    assign hit = (head.pc == bus.ref_pc) && (head.wnum == bus.ref_wnum)
                 && (head.wdata == (bus.ref_wdata & byte_mask(head.mask)));

    // A full FIFO still accepts a push when the head pops in the same cycle.
    assign push = capture && (state == ST_RUN) && (!full || fire);
    // Any write after end of test is a stray retire.
    assign over = capture && ((state == ST_DONE) || (full && !fire));

    assign end_now = (bus.debug_wb_pc == END_PC)
                     && ((bus.debug_wb_rf_we != 4'd0) || (bus.debug_wb_pc != prev_pc));

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fire),
        .wdata (cap_entry),
        .rdata (head_bits),
        .full  (full),
        .empty (empty)
    );

    // Track the previous PC and remember that the end PC has retired.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc  <= '0;
            end_seen <= 1'b0;
        end else begin
            prev_pc <= bus.debug_wb_pc;
            if (end_now)
                end_seen <= 1'b1;
        end
    end

    // Checker FSM with registered sticky status, error capture and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            mismatch   <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
            err_pc     <= '0;
            err_wnum   <= '0;
            err_wdata  <= '0;
            retire_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (fire && hit)
                        retire_cnt <= retire_cnt + 32'd1;
                    if (fire && !hit) begin
                        mismatch  <= 1'b1;
                        err_pc    <= head.pc;
                        err_wnum  <= head.wnum;
                        err_wdata <= head.wdata;
                    end
                    if (over)
                        overflow <= 1'b1;
                    if ((fire && !hit) || over) begin
                        state <= ST_ERROR;
                    end else if (end_seen && empty && !capture) begin
                        // Only finish when nothing is about to land in the FIFO.
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (over) begin
                        overflow <= 1'b1;
                        state    <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker with a golden-stream driver and a
// scoreboard monitor that checks the result of every compare handshake.
module tb_trace_checker;

    localparam logic [31:0] END_PC = 32'h1c000100;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } gold_t;

    typedef struct {
        logic        mism;
        logic [31:0] retire;
        logic [31:0] epc;
        logic [4:0]  ewnum;
        logic [31:0] edata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mismatch, overflow, done;
    logic [31:0] err_pc, err_wdata, retire_cnt;
    logic [4:0]  err_wnum;

    gold_t gq[$];
    exp_t  eq[$];
    logic  gold_en = 1'b0;
    logic  drv_fire;
    logic  mon_pending;
    exp_t  mon_cur;
    int    n_pass  = 0;
    int    n_total = 0;

    trace_checker_if bus();

    trace_checker #(
        .FIFO_DEPTH (8),
        .END_PC     (END_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mismatch   (mismatch),
        .overflow   (overflow),
        .done       (done),
        .err_pc     (err_pc),
        .err_wnum   (err_wnum),
        .err_wdata  (err_wdata),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: actual %h required %h", name, act, req);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.debug_wb_pc       = 32'h0;
        bus.debug_wb_rf_we    = 4'h0;
        bus.debug_wb_rf_wnum  = 5'h0;
        bus.debug_wb_rf_wdata = 32'h0;
    endtask

    // Drive one write-back for one cycle; called just after a rising edge.
    task automatic cap(input logic [31:0] pc, input logic [4:0] wnum,
                       input logic [3:0] we, input logic [31:0] data);
        bus.debug_wb_pc       = pc;
        bus.debug_wb_rf_wnum  = wnum;
        bus.debug_wb_rf_we    = we;
        bus.debug_wb_rf_wdata = data;
        @(posedge clk);
        #1;
        idle();
    endtask

    // Queue a golden entry together with the outcome its compare must produce.
    task automatic add(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] gdata,
                       input logic mism, input logic [31:0] retire,
                       input logic [31:0] epc, input logic [4:0] ewnum, input logic [31:0] edata);
        gold_t g;
        exp_t  e;
        g.pc = pc; g.wnum = wnum; g.wdata = gdata;
        e.mism = mism; e.retire = retire; e.epc = epc; e.ewnum = ewnum; e.edata = edata;
        gq.push_back(g);
        eq.push_back(e);
    endtask

    task automatic do_reset();
        gold_en = 1'b0;
        reset   = 1'b1;
        idle();
        gq.delete();
        eq.delete();
        cycles(2);
        reset = 1'b0;
    endtask

    // Golden stream driver: presents the queue head, advances on handshake.
    initial begin
        bus.ref_valid = 1'b0;
        bus.ref_pc    = 32'h0;
        bus.ref_wnum  = 5'h0;
        bus.ref_wdata = 32'h0;
        forever begin
            @(negedge clk);
            drv_fire = !reset && bus.ref_valid && bus.ref_ready;
            @(posedge clk);
            #1;
            if (drv_fire && gq.size() > 0)
                void'(gq.pop_front());
            if (gold_en && gq.size() > 0) begin
                bus.ref_valid = 1'b1;
                bus.ref_pc    = gq[0].pc;
                bus.ref_wnum  = gq[0].wnum;
                bus.ref_wdata = gq[0].wdata;
            end else begin
                bus.ref_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: each handshake pops one expectation, checked a cycle later.
    initial begin
        mon_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_pending = 1'b0;
            end else begin
                if (mon_pending) begin
                    chk("cmp_retire_cnt", retire_cnt, mon_cur.retire);
                    chk("cmp_mismatch", 32'(mismatch), 32'(mon_cur.mism));
                    if (mon_cur.mism) begin
                        chk("cmp_err_pc", err_pc, mon_cur.epc);
                        chk("cmp_err_wnum", 32'(err_wnum), 32'(mon_cur.ewnum));
                        chk("cmp_err_wdata", err_wdata, mon_cur.edata);
                    end
                    mon_pending = 1'b0;
                end
                if (bus.ref_valid && bus.ref_ready) begin
                    if (eq.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_compare: actual pc %h required no compare", bus.ref_pc);
                    end else begin
                        mon_cur     = eq.pop_front();
                        mon_pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        cycles(2);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_pc", err_pc, 32'd0);
        chk("rst_err_wnum", 32'(err_wnum), 32'd0);
        chk("rst_err_wdata", err_wdata, 32'd0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_ref_ready", 32'(bus.ref_ready), 32'd0);
        reset = 1'b0;
        cycles(1);

        // Directed match: r1..r5, data 0x11..0x55.
        do_reset();
        for (int i = 1; i <= 5; i++)
            add(32'h1c000000 + 32'(4 * i), 5'(i), 32'h11 * 32'(i), 1'b0, 32'(i), 32'h0, 5'h0, 32'h0);
        gold_en = 1'b1;
        for (int i = 1; i <= 5; i++)
            cap(32'h1c000000 + 32'(4 * i), 5'(i), 4'hF, 32'h11 * 32'(i));
        cycles(6);
        chk("match_retire_cnt", retire_cnt, 32'd5);
        chk("match_mismatch", 32'(mismatch), 32'd0);
        chk("match_ref_ready_drop", 32'(bus.ref_ready), 32'd0);
        chk("match_all_compared", 32'(eq.size()), 32'd0);

        // Data mismatch on the third entry.
        do_reset();
        add(32'h1c000200, 5'd1, 32'h11, 1'b0, 32'd1, 32'h0, 5'h0, 32'h0);
        add(32'h1c000204, 5'd2, 32'h22, 1'b0, 32'd2, 32'h0, 5'h0, 32'h0);
        add(32'h1c000208, 5'd3, 32'h34, 1'b1, 32'd2, 32'h1c000208, 5'd3, 32'h33);
        gold_en = 1'b1;
        cap(32'h1c000200, 5'd1, 4'hF, 32'h11);
        cap(32'h1c000204, 5'd2, 4'hF, 32'h22);
        cap(32'h1c000208, 5'd3, 4'hF, 32'h33);
        cycles(6);
        chk("mm_mismatch", 32'(mismatch), 32'd1);
        chk("mm_retire_cnt", retire_cnt, 32'd2);
        chk("mm_ref_ready", 32'(bus.ref_ready), 32'd0);
        chk("mm_all_compared", 32'(eq.size()), 32'd0);

        // Filtering and byte masking.
        do_reset();
        add(32'h1c000308, 5'd7, 32'h0000BEEF, 1'b0, 32'd1, 32'h0, 5'h0, 32'h0);
        add(32'h1c00030c, 5'd8, 32'hCAFE1234, 1'b0, 32'd2, 32'h0, 5'h0, 32'h0);
        gold_en = 1'b1;
        cap(32'h1c000300, 5'd0, 4'hF, 32'h1234);
        cap(32'h1c000304, 5'd5, 4'h0, 32'h5678);
        chk("filt_no_push", 32'(bus.ref_ready), 32'd0);
        cap(32'h1c000308, 5'd7, 4'b0011, 32'hDEADBEEF);
        cap(32'h1c00030c, 5'd8, 4'b1100, 32'hCAFEF00D);
        cycles(5);
        chk("filt_retire_cnt", retire_cnt, 32'd2);
        chk("filt_mismatch", 32'(mismatch), 32'd0);
        chk("filt_all_compared", 32'(eq.size()), 32'd0);

        // Overflow: ninth capture with no golden traffic.
        do_reset();
        for (int i = 1; i <= 8; i++)
            cap(32'h1c000400 + 32'(4 * i), 5'(i), 4'hF, 32'(i));
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        chk("ovf_ready_full", 32'(bus.ref_ready), 32'd1);
        cap(32'h1c000424, 5'd9, 4'hF, 32'd9);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_ready_error", 32'(bus.ref_ready), 32'd0);
        chk("ovf_err_pc_kept", err_pc, 32'd0);
        chk("ovf_no_mismatch", 32'(mismatch), 32'd0);

        // Ninth capture coincides with the first pop: accepted.
        do_reset();
        for (int i = 1; i <= 9; i++)
            add(32'h1c000500 + 32'(4 * i), 5'(i), 32'hA0 + 32'(i), 1'b0, 32'(i), 32'h0, 5'h0, 32'h0);
        for (int i = 1; i <= 8; i++)
            cap(32'h1c000500 + 32'(4 * i), 5'(i), 4'hF, 32'hA0 + 32'(i));
        @(negedge clk);
        gold_en = 1'b1;
        @(posedge clk);
        #1;
        cap(32'h1c000524, 5'd9, 4'hF, 32'hA9);
        chk("pp_no_overflow", 32'(overflow), 32'd0);
        cycles(12);
        chk("pp_overflow_clear", 32'(overflow), 32'd0);
        chk("pp_retire_cnt", retire_cnt, 32'd9);
        chk("pp_mismatch", 32'(mismatch), 32'd0);
        chk("pp_ready_drained", 32'(bus.ref_ready), 32'd0);
        chk("pp_all_compared", 32'(eq.size()), 32'd0);

        // End of test at END_PC, then a stray retire.
        do_reset();
        add(32'h1c0000f0, 5'd3, 32'h77, 1'b0, 32'd1, 32'h0, 5'h0, 32'h0);
        add(END_PC,       5'd4, 32'h88, 1'b0, 32'd2, 32'h0, 5'h0, 32'h0);
        gold_en = 1'b1;
        cap(32'h1c0000f0, 5'd3, 4'hF, 32'h77);
        cap(END_PC,       5'd4, 4'hF, 32'h88);
        cycles(1);
        chk("end_done_not_yet", 32'(done), 32'd0);
        cycles(1);
        chk("end_done", 32'(done), 32'd1);
        chk("end_ready", 32'(bus.ref_ready), 32'd0);
        chk("end_retire_cnt", retire_cnt, 32'd2);
        cap(32'h1c000104, 5'd5, 4'hF, 32'h99);
        chk("end_stray_overflow", 32'(overflow), 32'd1);
        chk("end_done_sticky", 32'(done), 32'd1);
        chk("end_no_mismatch", 32'(mismatch), 32'd0);

        // Asynchronous reset with three entries queued.
        do_reset();
        add(32'h1c000600, 5'd1, 32'hA1, 1'b0, 32'd1, 32'h0, 5'h0, 32'h0);
        add(32'h1c000604, 5'd2, 32'hA2, 1'b0, 32'd2, 32'h0, 5'h0, 32'h0);
        gold_en = 1'b1;
        cap(32'h1c000600, 5'd1, 4'hF, 32'hA1);
        cap(32'h1c000604, 5'd2, 4'hF, 32'hA2);
        cycles(4);
        chk("ar_pre_retire", retire_cnt, 32'd2);
        gold_en = 1'b0;
        cycles(1);
        cap(32'h1c000610, 5'd3, 4'hF, 32'hC3);
        cap(32'h1c000614, 5'd4, 4'hF, 32'hC4);
        cap(32'h1c000618, 5'd5, 4'hF, 32'hC5);
        chk("ar_queued_ready", 32'(bus.ref_ready), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_retire_cnt", retire_cnt, 32'd0);
        chk("ar_ref_ready", 32'(bus.ref_ready), 32'd0);
        chk("ar_mismatch", 32'(mismatch), 32'd0);
        chk("ar_overflow", 32'(overflow), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        gq.delete();
        eq.delete();
        cycles(1);
        reset = 1'b0;
        add(32'h1c000700, 5'd6, 32'hB1, 1'b0, 32'd1, 32'h0, 5'h0, 32'h0);
        add(32'h1c000704, 5'd7, 32'hB2, 1'b0, 32'd2, 32'h0, 5'h0, 32'h0);
        gold_en = 1'b1;
        cap(32'h1c000700, 5'd6, 4'hF, 32'hB1);
        cap(32'h1c000704, 5'd7, 4'hF, 32'hB2);
        cycles(5);
        chk("ar_fresh_retire", retire_cnt, 32'd2);
        chk("ar_fresh_mismatch", 32'(mismatch), 32'd0);
        chk("ar_all_compared", 32'(eq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
- Receive-side consumer of the core's write-back trace port (debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata).
- Captures every architecturally visible register write into a small FIFO and compares it in order against a golden trace stream delivered over a valid/ready handshake.
- Latches the first mismatch and reports completion when the end PC retires.
- Sits in the simulation/FPGA test environment beside the CPU top, never inside the core.

Parameters:
- FIFO_DEPTH, 8, captured-entry buffer depth; power of two, at least 2.
- END_PC, 32'h1c000100, PC whose write-back marks end of test.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- debug_wb_pc  in  32  PC of the instruction in write-back
- debug_wb_rf_we  in  4  byte write enables from write-back
- debug_wb_rf_wnum  in  5  destination register number
- debug_wb_rf_wdata  in  32  write data
- ref_valid  in  1  golden entry available
- ref_ready  out  1  checker consumes the golden entry this cycle
- ref_pc  in  32  golden PC
- ref_wnum  in  5  golden register number
- ref_wdata  in  32  golden data
- mismatch  out  1  sticky; first compare failure seen
- overflow  out  1  sticky; capture with FIFO full
- done  out  1  sticky; END_PC retired and FIFO drained, no error
- err_pc  out  32  captured PC of the failing entry
- err_wnum  out  5  captured wnum of the failing entry
- err_wdata  out  32  captured masked data of the failing entry
- retire_cnt  out  32  number of matched compares; wraps modulo 2^32

Behaviour:
- Reset (async, active-high): FIFO empty; state RUN; all outputs 0, including ref_ready.
- Capture: push {pc, wnum, wdata & mask} when debug_wb_rf_we != 0 and debug_wb_rf_wnum != 0.
  - mask = byte expansion of we (we[i] → byte i = 8'hFF).
  - Capture happens in every state except ERROR; captures are ignored in ERROR.
- Golden data is masked with the same mask stored alongside the entry. Mask is 4 bits per entry.
- FSM states: RUN, ERROR, DONE.
- RUN:
  - ref_ready = FIFO non-empty (combinational).
  - A compare fires on ref_valid && ref_ready. It pops one FIFO entry and consumes one golden entry in the same cycle.
  - Match (pc, wnum and masked data all equal): retire_cnt += 1 on the next edge.
  - Mismatch: set mismatch, latch err_* from the FIFO head, go to ERROR next cycle. retire_cnt does not increment.
- ERROR: terminal until reset. ref_ready = 0; err_* frozen.
- Overflow: a push attempted while FIFO is full sets overflow and moves to ERROR; the entry is dropped and err_* is not updated.
  - A push while full is accepted if a pop fires in the same cycle. Push and pop in the same cycle leave occupancy unchanged.
- End detection:
  - end_seen (internal, sticky) is set when debug_wb_pc == END_PC with debug_wb_rf_we != 0, or when debug_wb_pc == END_PC is observed changing from the previous cycle's PC.
  - RUN → DONE when end_seen && FIFO empty && no compare failure in that cycle.
  - In DONE: ref_ready = 0; captures still push, but any push sets overflow and moves to ERROR (stray retire after end).
- Compare latency: one FIFO entry per cycle max; a capture is comparable the cycle after its push (no bypass from push to head).
- Width rules: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB difference.

Decomposition:
- Shared package/header holds the state encodings (RUN/ERROR/DONE) and the entry width macro: 32+5+32+4 = 73.
- One natural sub-module: trace_fifo, a synchronous FIFO with async reset, push/pop/full/empty, and parameterised width/depth.
- The FSM, mask generation and compare live in trace_checker.

Test Plan:
- Directed match: 5 writes r1..r5 with data 0x11..0x55 (we=4'hF), golden identical, ref_valid held 1 → retire_cnt=5; mismatch=0; ref_ready drops when FIFO empties.
- Data mismatch: third golden entry has wdata 0x34 vs captured 0x33 → mismatch=1 one cycle after compare; err_pc/err_wnum/err_wdata = third entry; retire_cnt=2; ref_ready=0 thereafter.
- Filtering and masking:
  - Write with wnum=0 or we=0 → no push, retire_cnt unchanged.
  - we=4'b0011 with wdata 0xDEADBEEF vs golden 0x0000BEEF → match.
- Backpressure/overflow: ref_valid=0, 8 captures fill the FIFO.
  - Ninth capture alone → overflow=1, ERROR.
  - Repeat with ref_valid=1 on the same cycle as the ninth capture → no overflow, occupancy stays 8.
- End of test: last capture at pc=END_PC, golden matching → done=1 the cycle after the FIFO empties; a later capture → overflow=1, done stays 1.
- Async reset mid-run: assert reset between clock edges with 3 entries queued → all outputs 0 immediately, FIFO empty; after release, a fresh 2-entry stream gives retire_cnt=2.
